// File: rtl/mem_req_arbiter_if.sv
// Bundle of channel-side and downstream read/write handshake signals for mem_req_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface mem_req_arbiter_if #(
    parameter int NCH = 3,
    parameter int LW  = 128
);
    logic [NCH-1:0]    ch_rd_req;
    logic [3*NCH-1:0]  ch_rd_type;
    logic [32*NCH-1:0] ch_rd_addr;
    logic [NCH-1:0]    ch_rd_rdy;
    logic [NCH-1:0]    ch_ret_valid;
    logic [NCH-1:0]    ch_ret_last;
    logic [31:0]       ch_ret_data;

    logic [NCH-1:0]    ch_wr_req;
    logic [3*NCH-1:0]  ch_wr_type;
    logic [32*NCH-1:0] ch_wr_addr;
    logic [4*NCH-1:0]  ch_wr_wstrb;
    logic [LW*NCH-1:0] ch_wr_data;
    logic [NCH-1:0]    ch_wr_rdy;

    logic              rd_req;
    logic [2:0]        rd_type;
    logic [31:0]       rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;

    logic              wr_req;
    logic [2:0]        wr_type;
    logic [31:0]       wr_addr;
    logic [3:0]        wr_wstrb;
    logic [LW-1:0]     wr_data;
    logic              wr_rdy;

    modport slave (
        input  ch_rd_req, ch_rd_type, ch_rd_addr,
        output ch_rd_rdy, ch_ret_valid, ch_ret_last, ch_ret_data,
        input  ch_wr_req, ch_wr_type, ch_wr_addr, ch_wr_wstrb, ch_wr_data,
        output ch_wr_rdy,
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  wr_rdy
    );

    modport master (
        output ch_rd_req, ch_rd_type, ch_rd_addr,
        input  ch_rd_rdy, ch_ret_valid, ch_ret_last, ch_ret_data,
        output ch_wr_req, ch_wr_type, ch_wr_addr, ch_wr_wstrb, ch_wr_data,
        input  ch_wr_rdy,
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output wr_rdy
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// N-channel read/write request arbiter in front of a single memory port.
// Read and write paths arbitrate independently (round-robin or fixed priority).
//
// state  | meaning
// R_IDLE | no read outstanding; grant the next requester
// R_REQ  | downstream read request presented, waiting for rd_rdy
// R_DATA | routing return beats to the granted channel until the last beat
// W_IDLE | no write outstanding; grant the next requester
// W_REQ  | downstream write request presented, waiting for wr_rdy
module mem_req_arbiter #(
    parameter int NCH  = 3,
    parameter int LW   = 128,
    parameter int MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_req_arbiter_if.slave bus,
    output logic             proto_err
);
    localparam int GW = $clog2(NCH);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
    typedef enum logic       {W_IDLE, W_REQ}         wr_state_t;

    rd_state_t     rd_state_q, rd_state_d;
    logic [GW-1:0] rd_gnt_q, rd_gnt_d;
    logic [GW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    rd_type_q, rd_type_d;
    logic [31:0]   rd_addr_q, rd_addr_d;

    wr_state_t     wr_state_q, wr_state_d;
    logic [GW-1:0] wr_gnt_q, wr_gnt_d;
    logic [GW-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]    wr_type_q, wr_type_d;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [3:0]    wr_wstrb_q, wr_wstrb_d;
    logic [LW-1:0] wr_data_q, wr_data_d;

    logic          proto_err_q, proto_err_d;

    // Round-robin searches upward from ptr with wrap; fixed priority searches from 0.
    function automatic logic [GW-1:0] pick(input logic [NCH-1:0] req, input logic [GW-1:0] ptr);
        logic [GW-1:0] res;
        logic [GW-1:0] idx;
        logic          found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (MODE == 1) idx = GW'(k);
            else           idx = GW'((int'(ptr) + k) % NCH);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
        return (int'(g) == NCH - 1) ? '0 : g + GW'(1);
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [GW-1:0] g, input logic b);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = b && (GW'(i) == g);
        return v;
    endfunction

    always_comb begin
        rd_state_d          = rd_state_q;
        rd_gnt_d            = rd_gnt_q;
        rd_ptr_d            = rd_ptr_q;
        rd_type_d           = rd_type_q;
        rd_addr_d           = rd_addr_q;
        proto_err_d         = proto_err_q;
        bus.rd_req          = 1'b0;
        bus.ch_rd_rdy       = '0;
        bus.ch_ret_valid    = '0;
        bus.ch_ret_last     = '0;
        bus.ch_ret_data     = '0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (|bus.ch_rd_req) begin
                    rd_gnt_d = pick(bus.ch_rd_req, rd_ptr_q);
                    for (int i = 0; i < NCH; i++) begin
                        if (GW'(i) == rd_gnt_d) begin
                            rd_type_d = bus.ch_rd_type[3*i +: 3];
                            rd_addr_d = bus.ch_rd_addr[32*i +: 32];
                        end
                    end
                    rd_state_d = R_REQ;
                end
                if (bus.ret_valid) proto_err_d = 1'b1;
            end
            R_REQ: begin
                bus.rd_req    = rst_n;
                bus.ch_rd_rdy = onehot(rd_gnt_q, bus.rd_rdy && rst_n);
                if (bus.rd_rdy) rd_state_d = R_DATA;
                if (bus.ret_valid) proto_err_d = 1'b1;
            end
            R_DATA: begin
                bus.ch_ret_valid = onehot(rd_gnt_q, bus.ret_valid && rst_n);
                bus.ch_ret_last  = onehot(rd_gnt_q, bus.ret_last && rst_n);
                bus.ch_ret_data  = (bus.ret_valid && rst_n) ? bus.ret_data : '0;
                if (bus.ret_valid && bus.ret_last) begin
                    rd_state_d = R_IDLE;
                    rd_ptr_d   = next_ptr(rd_gnt_q);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_gnt_d      = wr_gnt_q;
        wr_ptr_d      = wr_ptr_q;
        wr_type_d     = wr_type_q;
        wr_addr_d     = wr_addr_q;
        wr_wstrb_d    = wr_wstrb_q;
        wr_data_d     = wr_data_q;
        bus.wr_req    = 1'b0;
        bus.ch_wr_rdy = '0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (|bus.ch_wr_req) begin
                    wr_gnt_d = pick(bus.ch_wr_req, wr_ptr_q);
                    for (int i = 0; i < NCH; i++) begin
                        if (GW'(i) == wr_gnt_d) begin
                            wr_type_d  = bus.ch_wr_type[3*i +: 3];
                            wr_addr_d  = bus.ch_wr_addr[32*i +: 32];
                            wr_wstrb_d = bus.ch_wr_wstrb[4*i +: 4];
                            wr_data_d  = bus.ch_wr_data[LW*i +: LW];
                        end
                    end
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                bus.wr_req    = rst_n;
                bus.ch_wr_rdy = onehot(wr_gnt_q, bus.wr_rdy && rst_n);
                if (bus.wr_rdy) begin
                    wr_state_d = W_IDLE;
                    wr_ptr_d   = next_ptr(wr_gnt_q);
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q  <= R_IDLE;
            rd_gnt_q    <= '0;
            rd_ptr_q    <= '0;
            rd_type_q   <= '0;
            rd_addr_q   <= '0;
            wr_state_q  <= W_IDLE;
            wr_gnt_q    <= '0;
            wr_ptr_q    <= '0;
            wr_type_q   <= '0;
            wr_addr_q   <= '0;
            wr_wstrb_q  <= '0;
            wr_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_gnt_q    <= rd_gnt_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_type_q   <= rd_type_d;
            rd_addr_q   <= rd_addr_d;
            wr_state_q  <= wr_state_d;
            wr_gnt_q    <= wr_gnt_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_type_q   <= wr_type_d;
            wr_addr_q   <= wr_addr_d;
            wr_wstrb_q  <= wr_wstrb_d;
            wr_data_q   <= wr_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.rd_type  = rd_type_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_type  = wr_type_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_wstrb = wr_wstrb_q;
    assign bus.wr_data  = wr_data_q;
    assign proto_err    = proto_err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus stream.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_req_arbiter;
    localparam int NCH = 3;
    localparam int LW  = 128;

    logic clk = 1'b0;
    logic rst_n;
    logic proto_err0, proto_err1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_req_arbiter_if #(.NCH(NCH), .LW(LW)) bus0 ();
    mem_req_arbiter_if #(.NCH(NCH), .LW(LW)) bus1 ();

    mem_req_arbiter #(.NCH(NCH), .LW(LW), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .proto_err(proto_err0)
    );
    mem_req_arbiter #(.NCH(NCH), .LW(LW), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .proto_err(proto_err1)
    );

    assign bus1.ch_rd_req   = bus0.ch_rd_req;
    assign bus1.ch_rd_type  = bus0.ch_rd_type;
    assign bus1.ch_rd_addr  = bus0.ch_rd_addr;
    assign bus1.ch_wr_req   = bus0.ch_wr_req;
    assign bus1.ch_wr_type  = bus0.ch_wr_type;
    assign bus1.ch_wr_addr  = bus0.ch_wr_addr;
    assign bus1.ch_wr_wstrb = bus0.ch_wr_wstrb;
    assign bus1.ch_wr_data  = bus0.ch_wr_data;
    assign bus1.rd_rdy      = bus0.rd_rdy;
    assign bus1.ret_valid   = bus0.ret_valid;
    assign bus1.ret_last    = bus0.ret_last;
    assign bus1.ret_data    = bus0.ret_data;
    assign bus1.wr_rdy      = bus0.wr_rdy;

    task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One read transaction with rd_rdy held high; exp0/exp1 are the one-hot grants
    // expected from the round-robin and fixed-priority instances.
    task automatic rd_txn(input string tag, input logic [2:0] exp0, input logic [2:0] exp1,
                          input logic chk1, input int beats, input int exp_wait, input logic gap);
        int          n;
        logic [31:0] d;
        n = 0;
        @(negedge clk);
        while (!bus0.rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_vec({tag, "_rd_req"}, bus0.rd_req, 1'b1);
        chk_vec({tag, "_lat"}, n, exp_wait);
        chk_vec({tag, "_rdy"}, bus0.ch_rd_rdy, exp0);
        if (chk1) chk_vec({tag, "_rdy_fp"}, bus1.ch_rd_rdy, exp1);
        if (gap) begin
            step();
            bus0.ret_valid = 1'b0;
            bus0.ret_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            chk_vec({tag, "_gap_valid"}, bus0.ch_ret_valid, 3'b000);
            chk_vec({tag, "_gap_data"}, bus0.ch_ret_data, 32'h0);
        end
        for (int b = 0; b < beats; b++) begin
            step();
            d = 32'hC0DE_0000 | (32'(exp0) << 8) | 32'(b);
            bus0.ret_valid = 1'b1;
            bus0.ret_last  = (b == beats - 1);
            bus0.ret_data  = d;
            @(negedge clk);
            chk_vec({tag, "_valid"}, bus0.ch_ret_valid, exp0);
            chk_vec({tag, "_last"}, bus0.ch_ret_last, (b == beats - 1) ? exp0 : 3'b000);
            chk_vec({tag, "_data"}, bus0.ch_ret_data, d);
            if (chk1) chk_vec({tag, "_valid_fp"}, bus1.ch_ret_valid, exp1);
        end
        step();
        bus0.ret_valid = 1'b0;
        bus0.ret_last  = 1'b0;
        bus0.ret_data  = 32'h0;
    endtask

    task automatic wr_txn(input string tag, input logic [2:0] exp0, input logic [31:0] addr0);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus0.wr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_vec({tag, "_wr_req"}, bus0.wr_req, 1'b1);
        chk_vec({tag, "_lat"}, n, 1);
        chk_vec({tag, "_rdy"}, bus0.ch_wr_rdy, exp0);
        chk_vec({tag, "_addr"}, bus0.wr_addr, addr0);
        chk_vec({tag, "_rdy_fp"}, bus1.ch_wr_rdy, 3'b001);
        chk_vec({tag, "_addr_fp"}, bus1.wr_addr, 32'h0000_1110);
        step();
    endtask

    initial begin
        int pulses;
        rst_n            = 1'b0;
        bus0.ch_rd_req   = '0;
        bus0.ch_rd_type  = '0;
        bus0.ch_rd_addr  = '0;
        bus0.ch_wr_req   = '0;
        bus0.ch_wr_type  = '0;
        bus0.ch_wr_addr  = '0;
        bus0.ch_wr_wstrb = '0;
        bus0.ch_wr_data  = '0;
        bus0.rd_rdy      = 1'b0;
        bus0.ret_valid   = 1'b0;
        bus0.ret_last    = 1'b0;
        bus0.ret_data    = '0;
        bus0.wr_rdy      = 1'b0;

        repeat (3) step();
        @(negedge clk);
        chk_vec("rst_rd_req", bus0.rd_req, 1'b0);
        chk_vec("rst_wr_req", bus0.wr_req, 1'b0);
        chk_vec("rst_rd_rdy", bus0.ch_rd_rdy, 3'b000);
        chk_vec("rst_proto", proto_err0, 1'b0);

        step();
        rst_n          = 1'b1;
        bus0.ch_rd_req = 3'b111;
        bus0.rd_rdy    = 1'b1;
        @(negedge clk);
        chk_vec("rel_rd_req", bus0.rd_req, 1'b0);
        chk_vec("rel_rd_rdy", bus0.ch_rd_rdy, 3'b000);

        // all three channels requesting: round-robin rotates, fixed priority sticks on 0
        rd_txn("rr0", 3'b001, 3'b001, 1'b1, 4, 0, 1'b1);
        rd_txn("rr1", 3'b010, 3'b001, 1'b1, 4, 1, 1'b0);
        rd_txn("rr2", 3'b100, 3'b001, 1'b1, 4, 1, 1'b0);
        rd_txn("rr3", 3'b001, 3'b001, 1'b1, 4, 1, 1'b0);
        bus0.ch_rd_req = 3'b000;
        bus0.rd_rdy    = 1'b0;

        // stalled read on ch1 with a concurrent write from ch2
        bus0.ch_rd_type = {3'd0, 3'd2, 3'd0};
        bus0.ch_rd_addr = {32'h0, 32'h1FAF_0000, 32'h0};
        bus0.ch_rd_req  = 3'b010;
        step();
        bus0.ch_wr_type  = {3'd5, 3'd1, 3'd3};
        bus0.ch_wr_addr  = {32'h0000_4440, 32'h0000_2220, 32'h0000_1110};
        bus0.ch_wr_wstrb = {4'hF, 4'h3, 4'h1};
        bus0.ch_wr_data  = {128'h2222_0000_2222_0000_2222_0000_2222_0002,
                            128'h1111_0000_1111_0000_1111_0000_1111_0001,
                            128'h0000_AAAA_0000_AAAA_0000_AAAA_0000_AAAA};
        bus0.ch_wr_req   = 3'b100;
        bus0.wr_rdy      = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_vec("stall_rd_req", bus0.rd_req, 1'b1);
            chk_vec("stall_addr", bus0.rd_addr, 32'h1FAF_0000);
            chk_vec("stall_type", bus0.rd_type, 3'd2);
            chk_vec("stall_rd_rdy", bus0.ch_rd_rdy, 3'b000);
            pulses += int'(bus0.ch_wr_rdy[2]);
            if (c == 1) begin
                chk_vec("cw_wr_req", bus0.wr_req, 1'b1);
                chk_vec("cw_rdy", bus0.ch_wr_rdy, 3'b100);
                chk_vec("cw_addr", bus0.wr_addr, 32'h0000_4440);
                chk_vec("cw_type", bus0.wr_type, 3'd5);
                chk_vec("cw_wstrb", bus0.wr_wstrb, 4'hF);
                chk_vec("cw_data", bus0.wr_data, 128'h2222_0000_2222_0000_2222_0000_2222_0002);
            end
            step();
            if (c == 1) begin
                bus0.ch_wr_req  = 3'b000;
                bus0.ch_wr_data = '0;
            end
            if (c == 2) bus0.rd_rdy = 1'b1;
        end
        @(negedge clk);
        chk_vec("accept_rd_req", bus0.rd_req, 1'b1);
        chk_vec("accept_rd_rdy", bus0.ch_rd_rdy, 3'b010);
        chk_vec("accept_wr_req", bus0.wr_req, 1'b0);
        pulses += int'(bus0.ch_wr_rdy[2]);
        chk_vec("wr_rdy_pulses", pulses, 1);
        step();
        bus0.ch_rd_req = 3'b000;
        bus0.rd_rdy    = 1'b0;
        bus0.ret_valid = 1'b1;
        bus0.ret_last  = 1'b1;
        bus0.ret_data  = 32'h5A5A_0001;
        @(negedge clk);
        chk_vec("st_ret_valid", bus0.ch_ret_valid, 3'b010);
        chk_vec("st_ret_last", bus0.ch_ret_last, 3'b010);
        chk_vec("st_ret_data", bus0.ch_ret_data, 32'h5A5A_0001);
        step();
        bus0.ret_valid = 1'b0;
        bus0.ret_last  = 1'b0;
        bus0.ret_data  = 32'h0;

        // write path rotation: wr_ptr is at 0 after the ch2 write
        bus0.ch_wr_req = 3'b111;
        bus0.wr_rdy    = 1'b1;
        wr_txn("wrr0", 3'b001, 32'h0000_1110);
        wr_txn("wrr1", 3'b010, 32'h0000_2220);
        bus0.ch_wr_req = 3'b000;
        bus0.wr_rdy    = 1'b0;

        // stray return beat while idle
        @(negedge clk);
        chk_vec("pe_before", proto_err0, 1'b0);
        step();
        bus0.ret_valid = 1'b1;
        bus0.ret_last  = 1'b1;
        bus0.ret_data  = 32'h1234_5678;
        @(negedge clk);
        chk_vec("pe_valid", bus0.ch_ret_valid, 3'b000);
        chk_vec("pe_data", bus0.ch_ret_data, 32'h0);
        step();
        bus0.ret_valid = 1'b0;
        bus0.ret_last  = 1'b0;
        bus0.ret_data  = 32'h0;
        @(negedge clk);
        chk_vec("pe_set", proto_err0, 1'b1);
        repeat (3) step();
        @(negedge clk);
        chk_vec("pe_sticky", proto_err0, 1'b1);

        // reset in the middle of a ch2 burst (rd_ptr is 2 here)
        step();
        bus0.ch_rd_req = 3'b100;
        bus0.rd_rdy    = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus0.rd_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk_vec("ab_rdy", bus0.ch_rd_rdy, 3'b100);
        end
        for (int b = 0; b < 2; b++) begin
            step();
            bus0.ret_valid = 1'b1;
            bus0.ret_data  = 32'h7700_0000 | 32'(b);
            @(negedge clk);
            chk_vec("ab_valid", bus0.ch_ret_valid, 3'b100);
        end
        step();
        rst_n          = 1'b0;
        bus0.ch_rd_req = 3'b000;
        bus0.ret_data  = 32'h7700_0002;
        @(negedge clk);
        chk_vec("inrst_valid", bus0.ch_ret_valid, 3'b000);
        chk_vec("inrst_data", bus0.ch_ret_data, 32'h0);
        chk_vec("inrst_rd_req", bus0.rd_req, 1'b0);
        step();
        rst_n          = 1'b1;
        bus0.ret_last  = 1'b1;
        bus0.ret_data  = 32'h7700_0003;
        @(negedge clk);
        chk_vec("post_valid", bus0.ch_ret_valid, 3'b000);
        chk_vec("post_data", bus0.ch_ret_data, 32'h0);
        chk_vec("post_proto", proto_err0, 1'b0);
        chk_vec("post_rd_req", bus0.rd_req, 1'b0);
        step();
        bus0.ret_valid = 1'b0;
        bus0.ret_last  = 1'b0;
        bus0.ret_data  = 32'h0;
        bus0.ch_rd_req = 3'b110;
        @(negedge clk);
        chk_vec("post_proto_set", proto_err0, 1'b1);
        rd_txn("after_rst", 3'b010, 3'b010, 1'b1, 2, 0, 1'b0);
        bus0.ch_rd_req = 3'b000;
        @(negedge clk);
        chk_vec("final_proto", proto_err0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NCH, default 3: number of requesting channels (icache, dcache, uncache order), legal 2..8.
REQ-002 Parameter LW, default 128: write data width in bits (one cache line), legal 32..512, multiple of 32.
REQ-003 Parameter MODE, default 0: 0 = round-robin, 1 = fixed priority, channel 0 highest.
REQ-004 Port clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Ports ch_rd_req / ch_rd_type / ch_rd_addr  in  NCH / 3*NCH / 32*NCH  per-channel read requests, channel i in slice i.
REQ-007 Ports ch_rd_rdy / ch_ret_valid / ch_ret_last  out  NCH each  per-channel read accept and return strobes.
REQ-008 Port ch_ret_data  out  32  return beat, shared by all channels; qualified by ch_ret_valid.
REQ-009 Ports ch_wr_req / ch_wr_type / ch_wr_addr / ch_wr_wstrb / ch_wr_data  in  NCH / 3*NCH / 32*NCH / 4*NCH / LW*NCH  per-channel write requests.
REQ-010 Port ch_wr_rdy  out  NCH  per-channel write accept.
REQ-011 Ports rd_req / rd_type / rd_addr  out  1 / 3 / 32  downstream read request.
REQ-012 Ports rd_rdy / ret_valid / ret_last / ret_data  in  1 / 1 / 1 / 32  downstream read accept and return.
REQ-013 Ports wr_req / wr_type / wr_addr / wr_wstrb / wr_data  out  1 / 3 / 32 / 4 / LW  downstream write request.
REQ-014 Port wr_rdy  in  1  downstream write accept.
REQ-015 Port proto_err  out  1  sticky protocol-violation flag.

Function
REQ-016 The read path and the write path SHALL arbitrate independently; one read and one write may be in flight together.
REQ-017 Read FSM states: R_IDLE, R_REQ, R_DATA; write FSM states: W_IDLE, W_REQ.
REQ-018 R_IDLE with any ch_rd_req set: register grant index and that channel's type/addr; enter R_REQ next cycle.
REQ-019 MODE 0: grant the lowest-index requester at or above rd_ptr, wrapping past NCH-1 to 0; MODE 1: grant the lowest-index requester.
REQ-020 In R_REQ, rd_req = 1 with the registered type/addr; ch_rd_rdy[g] = rd_rdy combinationally; all other ch_rd_rdy bits = 0.
REQ-021 R_REQ with rd_rdy = 1: enter R_DATA next cycle; otherwise hold R_REQ with rd_req held high and fields held stable.
REQ-022 In R_DATA, ch_ret_valid[g] = ret_valid, ch_ret_last[g] = ret_last, ch_ret_data = ret_data, all combinational, zero added latency.
REQ-023 R_DATA with ret_valid & ret_last: return to R_IDLE next cycle; rd_ptr <= (g+1) mod NCH; a new grant can issue in that R_IDLE cycle.
REQ-024 Minimum read occupancy: request in cycle 0, rd_req in cycle 1, earliest next grant one cycle after the last beat.
REQ-025 W_IDLE with any ch_wr_req set: grant by the same MODE rule using separate wr_ptr; register index, type, addr, wstrb, data; enter W_REQ.
REQ-026 In W_REQ, wr_req = 1 with registered fields; ch_wr_rdy[g] = wr_rdy; on wr_rdy return to W_IDLE next cycle and wr_ptr <= (g+1) mod NCH.
REQ-027 Channels SHALL hold a request and its fields stable until their rdy bit is seen; the arbiter SHALL NOT sample fields after grant.
REQ-028 ret_valid in R_IDLE or R_REQ: beat dropped, no ch_ret_valid bit set, proto_err set to 1.
REQ-029 ch_ret_valid, ch_rd_rdy, ch_wr_rdy SHALL never have more than one bit set.
REQ-030 ch_ret_data SHALL be 0 when no ch_ret_valid bit is set.

Reset
REQ-031 rst_n = 0 at a rising edge: both FSMs to idle, rd_ptr = wr_ptr = 0, grants and registered fields 0, proto_err = 0.
REQ-032 While in reset and in the first cycle after, rd_req, wr_req, all ch_* outputs = 0.
REQ-033 Reset asserted mid-transaction abandons it; remaining downstream beats after release are handled per REQ-028.

Verification
REQ-034 NCH=3, MODE 0: ch_rd_req = 3'b111 held, rd_rdy = 1, 4-beat returns -> grants 0,1,2,0 in order, each ch_ret_valid burst 4 beats on the granted channel only.
REQ-035 MODE 1, same stimulus -> channel 0 granted every transaction; channels 1,2 never granted while ch_rd_req[0] = 1.
REQ-036 Read to ch1 addr 0x1FAF_0000 type 2 with rd_rdy low 3 cycles, then write from ch2 wstrb 4'hF -> rd_req held 3 cycles with stable addr; wr_req issues concurrently; ch_wr_rdy[2] pulses once.
REQ-037 ret_valid = 1 in R_IDLE -> no ch_ret_valid bit, proto_err = 1 and stays 1 until rst_n = 0.
REQ-038 rst_n = 0 during R_DATA after beat 2 of 4 -> next cycle all outputs 0, rd_ptr = 0, next request granted from channel 0 upward.
